pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the RISC-V core. It holds the fetch PC and advances it by 4 under a fetch handshake with hazard stall. It applies branch/jump redirects and trap entry with fixed priority, and traps misaligned redirect targets. It sits between the next-PC logic (branch unit, trap controller) and instruction memory, replacing the bare PC register.

## Interface
- XLEN, 32, address/PC width in bits
- RESET_VECTOR, 0, PC value loaded at reset; bits below log2(IALIGN) are forced to 0
- IALIGN, 4, required instruction alignment in bytes (2 or 4); only affects the misalignment check
- CNT_W, 32, width of the accepted-fetch counter

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_ready  in  1  instruction memory accepts the address on pc this cycle
- stall  in  1  hazard unit holds the PC (sequential advance suppressed)
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_target  in  XLEN  branch/jump target address
- trap_valid  in  1  exception/interrupt entry this cycle
- trap_vector  in  XLEN  trap handler address (assumed aligned by trap controller)
- pc  out  XLEN  current fetch address (registered)
- pc_plus4  out  XLEN  pc + 4 mod 2^XLEN (combinational, for link register)
- fetch_valid  out  1  pc is a valid fetch request
- misalign_fault  out  1  one-cycle pulse: redirect target was misaligned
- fault_addr  out  XLEN  offending target of the most recent misalign fault
- fetch_count  out  CNT_W  number of accepted fetches

## Operation
- Reset (reset_n low, async): pc=RESET_VECTOR (low bits cleared), fetch_valid=0, misalign_fault=0, fault_addr=0, fetch_count=0.
- Boot cycle: first rising edge after reset_n rises sets fetch_valid=1. pc is unchanged. fetch_valid then stays 1 until the next reset.
- While fetch_valid=0, all inputs are ignored and no state other than fetch_valid changes.
- accept = fetch_valid & fetch_ready & ~stall.
- Next-PC priority, evaluated every edge with fetch_valid=1:
  1. trap_valid: pc <= trap_vector. No fault, even if redirect_valid is also set.
  2. redirect_valid and target misaligned (target mod IALIGN != 0): pc <= trap_vector, misalign_fault <= 1, fault_addr <= redirect_target.
  3. redirect_valid, aligned: pc <= redirect_target.
  4. accept: pc <= pc + 4, wrapping mod 2^XLEN (0xFFFF_FFFC -> 0x0000_0000 at XLEN=32).
  5. otherwise: pc holds.
- Trap and redirect take effect regardless of stall and fetch_ready. They squash the current fetch.
- misalign_fault is 1 only in the cycle following the faulting edge. It clears on the next edge unless another fault occurs. fault_addr holds until the next fault or reset.
- fetch_count increments by 1 on every edge where accept=1, independent of which next-PC case is taken. It wraps at 2^CNT_W.
- Reset asserted mid-operation immediately forces all reset values. No pending state survives.

## Timing
- pc, fetch_valid, misalign_fault, fault_addr and fetch_count are all registered. pc_plus4 is combinational from pc.
- Redirect or trap latency: 1 cycle. The input is sampled at edge N and the new pc is visible after edge N.
- First valid fetch: pc=RESET_VECTOR with fetch_valid=1 after the first edge following reset release.
- Stall or fetch_ready=0 holds pc indefinitely. There is no timeout.
- No combinational path from any input to any output.

## Test plan
- Reset/boot: RESET_VECTOR=0x0000_1000, release reset_n -> pc=0x1000, fetch_valid=0; after 1 edge fetch_valid=1; 3 accepted edges -> pc=0x100C, fetch_count=3.
- Stall/ready: at pc=0x200, hold stall=1 for 2 edges, then fetch_ready=0 for 2 edges -> pc stays 0x200, fetch_count unchanged; release both -> next edge pc=0x204.
- Redirect under stall: stall=1, redirect_valid=1, target=0x400 -> pc=0x400 after one edge, fetch_count unchanged.
- Misalign: IALIGN=4, redirect_target=0x402, trap_vector=0x80 -> pc=0x80, misalign_fault high for exactly one cycle, fault_addr=0x402. Same target with IALIGN=2 -> pc=0x402, no fault.
- Priority: trap_valid=1 and redirect_valid=1 (target=0x3, misaligned) together, trap_vector=0x80 -> pc=0x80, misalign_fault stays 0, fault_addr unchanged.
- Wrap and async reset: pc=0xFFFF_FFFC accepted -> pc=0x0, pc_plus4=0x4; drop reset_n between edges -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC, advances it under the fetch handshake,
// applies trap/redirect with fixed priority and traps misaligned redirect targets.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vector,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             fetch_valid,
    output logic             misalign_fault,
    output logic [XLEN-1:0]  fault_addr,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] RESET_PC   = RESET_VECTOR & ~ALIGN_MASK;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_TARGET,
        SEL_TRAP
    } pc_sel_e;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             fault_q, fault_d;
    logic [XLEN-1:0]  fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic    accept;
    logic    target_misaligned;
    pc_sel_e pc_sel;

    assign accept            = fetch_valid_q & fetch_ready & ~stall;
    assign target_misaligned = |(redirect_target & ALIGN_MASK);

    // Trap beats redirect; a misaligned redirect is turned into a trap entry.
    always_comb begin
        pc_sel = SEL_HOLD;
        if (trap_valid) begin
            pc_sel = SEL_TRAP;
        end else if (redirect_valid) begin
            pc_sel = target_misaligned ? SEL_TRAP : SEL_TARGET;
        end else if (accept) begin
            pc_sel = SEL_SEQ;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        pc_d          = pc_q;
        fetch_valid_d = 1'b1;
        fault_d       = 1'b0;
        fault_addr_d  = fault_addr_q;
        count_d       = count_q;

        if (!fetch_valid_q) begin
            // Boot cycle: only the valid flag moves.
            fault_d = fault_q;
        end else begin
            unique case (pc_sel)
                SEL_TRAP:   pc_d = trap_vector;
                SEL_TARGET: pc_d = redirect_target;
                SEL_SEQ:    pc_d = pc_q + XLEN'(4);
                default:    pc_d = pc_q;
            endcase

            if (!trap_valid && redirect_valid && target_misaligned) begin
                fault_d      = 1'b1;
                fault_addr_d = redirect_target;
            end

            if (accept) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
            count_q       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fault_q       <= fault_d;
            fault_addr_q  <= fault_addr_d;
            count_q       <= count_d;
        end
    end

    assign pc             = pc_q;
    assign pc_plus4       = pc_q + XLEN'(4);
    assign fetch_valid    = fetch_valid_q;
    assign misalign_fault = fault_q;
    assign fault_addr     = fault_addr_q;
    assign fetch_count    = count_q;

endmodule
